// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: access sizes, MMIO map,
// requester ownership encoding and the saturating counter helper.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] SEG_ADDR  = 32'h0000_0000;
  localparam logic [31:0] UART_ADDR = 32'h0000_0004;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// One-deep read response register; steers the memory's synchronous read data
// to whichever requester issued the read, forcing zero for filtered reads.
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_v_i,
  input  logic          owner_i,
  input  logic          zero_i,
  input  logic [DW-1:0] m_rdata_i,
  output logic          c_rvalid_o,
  output logic [DW-1:0] c_rdata_o,
  output logic          l_rvalid_o,
  output logic [DW-1:0] l_rdata_o
);

  logic rd_v_q, rd_v_d;
  logic owner_q, owner_d;
  logic zero_q, zero_d;

  assign rd_v_d  = rd_v_i;
  assign owner_d = owner_i;
  assign zero_d  = zero_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v_q  <= 1'b0;
      owner_q <= OWN_CPU;
      zero_q  <= 1'b0;
    end else begin
      rd_v_q  <= rd_v_d;
      owner_q <= owner_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    c_rvalid_o = rd_v_q & (owner_q == OWN_CPU);
    l_rvalid_o = rd_v_q & (owner_q == OWN_LDR);
    c_rdata_o  = (c_rvalid_o & zero_q) ? '0 : m_rdata_i;
    l_rdata_o  = (l_rvalid_o & zero_q) ? '0 : m_rdata_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / UART loader) arbiter for the memory data port.
// Fixed loader priority by default; define MEM_PORT_ARB_RR_EN for round-robin.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] MMIO_TOP = 'h8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [2:0]    c_funct3,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic [2:0]    l_funct3,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  output logic          m_re,
  output logic [2:0]    m_funct3,
  input  logic [DW-1:0] m_rdata,
  output logic [15:0]   busy_cnt
);

  logic          c_elig, l_elig;
  logic          ldr_pri;
  logic          c_win, l_win, any_gnt;
  logic          win_we, l_filt, fwd;
  logic [AW-1:0] win_addr;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   busy_q, busy_d;
  logic          refused;
  logic          rsp_v, rsp_owner, rsp_zero;

  assign c_elig = c_req & ~boot;
  assign l_elig = l_req;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_CPU;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (l_win)      last_d = OWN_LDR;
    else if (c_win) last_d = OWN_CPU;
  end

  assign ldr_pri = (last_q == OWN_CPU);
`else
  assign ldr_pri = 1'b1;
`endif

  // Grants are masked while reset is asserted so nothing reaches the memory.
  always_comb begin
    l_win   = rst_n & l_elig & (~c_elig | ldr_pri);
    c_win   = rst_n & c_elig & ~l_win;
    any_gnt = c_win | l_win;
    c_gnt   = c_win;
    l_gnt   = l_win;
  end

  always_comb begin
    win_addr = l_win ? l_addr : c_addr;
    win_we   = l_win ? l_we : c_we;
    l_filt   = l_addr < MMIO_TOP;
    fwd      = c_win | (l_win & ~l_filt);
    m_we     = fwd & win_we;
    m_re     = fwd & ~win_we;
    m_addr   = any_gnt ? win_addr : addr_q;
    m_wdata  = '0;
    m_funct3 = 3'b000;
    if (l_win) begin
      m_wdata  = l_wdata;
      m_funct3 = l_funct3;
    end else if (c_win) begin
      m_wdata  = c_wdata;
      m_funct3 = c_funct3;
    end
  end

  always_comb begin
    addr_d  = any_gnt ? win_addr : addr_q;
    refused = (c_req & ~c_win) | (l_req & ~l_win);
    busy_d  = refused ? sat_inc16(busy_q) : busy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      busy_q <= '0;
    end else begin
      addr_q <= addr_d;
      busy_q <= busy_d;
    end
  end

  assign busy_cnt = busy_q;

  assign rsp_v     = any_gnt & ~win_we;
  assign rsp_owner = l_win ? OWN_LDR : OWN_CPU;
  assign rsp_zero  = l_win & l_filt;

  mem_rsp_pipe #(
    .DW(DW)
  ) u_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_v_i    (rsp_v),
    .owner_i   (rsp_owner),
    .zero_i    (rsp_zero),
    .m_rdata_i (m_rdata),
    .c_rvalid_o(c_rvalid),
    .c_rdata_o (c_rdata),
    .l_rvalid_o(l_rvalid),
    .l_rdata_o (l_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic [2:0]  c_funct3, l_funct3;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [31:0] c_rdata, l_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we, m_re;
  logic [2:0]  m_funct3;
  logic [15:0] busy_cnt;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .boot(boot),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_funct3(l_funct3),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_funct3(m_funct3),
    .m_rdata(m_rdata), .busy_cnt(busy_cnt)
  );

  // Memory block: synchronous read, word-granular write.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else begin
      if (m_we) mem[m_addr[11:2]] <= m_wdata;
      if (m_re) m_rdata <= mem[m_addr[11:2]];
    end
  end

  task automatic idle_inputs();
    boot = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_funct3 = 3'b010;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_funct3 = 3'b010;
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 10'(i); pl_data = ref_mem[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; c_req = 1'b1; l_req = 1'b1; l_addr = 32'h40; c_addr = 32'h80;
    #1;
    n_tests++; if (c_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_c_gnt got %b want 0", c_gnt); end
    n_tests++; if (l_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_l_gnt got %b want 0", l_gnt); end
    n_tests++; if ({m_we, m_re} !== 2'b00) begin n_fail++; $display("FAIL reset_m_we_re got %b want 00", {m_we, m_re}); end
    n_tests++; if ({c_rvalid, l_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {c_rvalid, l_rvalid}); end
    n_tests++; if (busy_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy_cnt); end
    n_tests++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr got %h want 0", m_addr); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read();
    apply_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
    #1;
    n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL cpu_read_gnt got %b want 1", c_gnt); end
    n_tests++; if (m_re !== 1'b1 || m_we !== 1'b0) begin n_fail++; $display("FAIL cpu_read_m_re got re=%b we=%b want re=1 we=0", m_re, m_we); end
    n_tests++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL cpu_read_m_addr got %h want 100", m_addr); end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    n_tests++; if (c_rvalid !== 1'b1) begin n_fail++; $display("FAIL cpu_read_rvalid got %b want 1", c_rvalid); end
    n_tests++; if (c_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_read_rdata got %h want deadbeef", c_rdata); end
    n_tests++; if (l_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_read_l_rvalid got %b want 0", l_rvalid); end
    n_tests++; if (m_re !== 1'b0 || m_addr !== 32'h100) begin n_fail++; $display("FAIL cpu_read_idle got re=%b addr=%h want re=0 addr=100", m_re, m_addr); end
  endtask

  task automatic test_conflict();
    logic [2:0] exp_l;
    exp_l = RR ? 3'b101 : 3'b111;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h1111_0000 + 32'(k);
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h14; l_wdata = 32'h2222_0000 + 32'(k);
      #1;
      n_tests++; if (l_gnt !== exp_l[k]) begin n_fail++; $display("FAIL conflict_l_gnt[%0d] got %b want %b", k, l_gnt, exp_l[k]); end
      n_tests++; if (c_gnt !== ~exp_l[k]) begin n_fail++; $display("FAIL conflict_c_gnt[%0d] got %b want %b", k, c_gnt, ~exp_l[k]); end
      n_tests++; if (m_we !== 1'b1 || m_wdata !== (exp_l[k] ? l_wdata : c_wdata))
        begin n_fail++; $display("FAIL conflict_m_w[%0d] got we=%b data=%h", k, m_we, m_wdata); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_tests++; if (busy_cnt !== 16'd3) begin n_fail++; $display("FAIL conflict_busy got %0d want 3", busy_cnt); end
  endtask

  task automatic test_mmio_filter();
    apply_reset();
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h4; l_wdata = 32'h55;
    #1;
    n_tests++; if (l_gnt !== 1'b1) begin n_fail++; $display("FAIL mmio_wr_gnt got %b want 1", l_gnt); end
    n_tests++; if ({m_we, m_re} !== 2'b00) begin n_fail++; $display("FAIL mmio_wr_fwd got %b want 00", {m_we, m_re}); end
    @(negedge clk);
    l_we = 1'b0; l_addr = 32'h0;
    #1;
    n_tests++; if (l_gnt !== 1'b1 || m_re !== 1'b0) begin n_fail++; $display("FAIL mmio_rd_issue got gnt=%b re=%b want gnt=1 re=0", l_gnt, m_re); end
    @(negedge clk);
    l_req = 1'b0;
    #1;
    n_tests++; if (l_rvalid !== 1'b1 || c_rvalid !== 1'b0) begin n_fail++; $display("FAIL mmio_rd_rvalid got l=%b c=%b want l=1 c=0", l_rvalid, c_rvalid); end
    n_tests++; if (l_rdata !== 32'h0) begin n_fail++; $display("FAIL mmio_rd_rdata got %h want 0", l_rdata); end
    @(negedge clk);
    #1;
    n_tests++; if (l_rvalid !== 1'b0) begin n_fail++; $display("FAIL mmio_rd_single got %b want 0", l_rvalid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h200;
    #1;
    n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_c_gnt got %b want 1", c_gnt); end
    @(negedge clk);
    c_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h204;
    #1;
    n_tests++; if (l_gnt !== 1'b1 || m_re !== 1'b1) begin n_fail++; $display("FAIL b2b_l_gnt got gnt=%b re=%b want 1 1", l_gnt, m_re); end
    n_tests++; if (c_rvalid !== 1'b1 || l_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_first_rvalid got c=%b l=%b want c=1 l=0", c_rvalid, l_rvalid); end
    n_tests++; if (c_rdata !== ref_mem[32'h200 >> 2]) begin n_fail++; $display("FAIL b2b_c_rdata got %h want %h", c_rdata, ref_mem[32'h200 >> 2]); end
    @(negedge clk);
    l_req = 1'b0;
    #1;
    n_tests++; if (l_rvalid !== 1'b1 || c_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_rvalid got l=%b c=%b want l=1 c=0", l_rvalid, c_rvalid); end
    n_tests++; if (l_rdata !== ref_mem[32'h204 >> 2]) begin n_fail++; $display("FAIL b2b_l_rdata got %h want %h", l_rdata, ref_mem[32'h204 >> 2]); end
  endtask

  task automatic test_boot();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      boot = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300;
      #1;
      n_tests++; if (c_gnt !== 1'b0 || m_re !== 1'b0) begin n_fail++; $display("FAIL boot_block[%0d] got gnt=%b re=%b want 0 0", k, c_gnt, m_re); end
    end
    @(negedge clk);
    boot = 1'b0;
    #1;
    n_tests++; if (busy_cnt !== 16'd5) begin n_fail++; $display("FAIL boot_busy got %0d want 5", busy_cnt); end
    n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL boot_release_gnt got %b want 1", c_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h120;
    #1;
    n_tests++; if (c_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_gnt got %b want 1", c_gnt); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if ({c_rvalid, l_rvalid, c_gnt, l_gnt, m_we, m_re} !== 6'b0)
      begin n_fail++; $display("FAIL rst_inflight_outs got %b want 000000", {c_rvalid, l_rvalid, c_gnt, l_gnt, m_we, m_re}); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_tests++; if (c_rvalid !== 1'b0 || m_re !== 1'b0 || m_addr !== 32'h0)
      begin n_fail++; $display("FAIL rst_inflight_release got rv=%b re=%b addr=%h want 0 0 0", c_rvalid, m_re, m_addr); end
  endtask

  // Transaction-level model: pick the winner from the arbitration rules,
  // apply forwarded writes to ref_mem, and queue each read's expected response.
  task automatic test_random();
    int          win;
    bit          last_ldr, c_hold, l_hold, filt, wwe;
    bit          pend_v, pend_ldr;
    logic [31:0] pend_data, hold_addr, waddr, wdata;
    int          exp_busy;
    preload();
    apply_reset();
    last_ldr = 1'b0; c_hold = 1'b0; l_hold = 1'b0; pend_v = 1'b0; pend_ldr = 1'b0;
    pend_data = '0; hold_addr = '0; exp_busy = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      boot = ($urandom_range(0, 7) == 0);
      if (!c_hold) begin
        c_req = $urandom_range(0, 1); c_we = $urandom_range(0, 1);
        c_addr = {20'd0, 6'($urandom_range(0, 63)), 2'b00}; c_wdata = $urandom;
      end
      if (!l_hold) begin
        l_req = $urandom_range(0, 1); l_we = $urandom_range(0, 1);
        l_addr = {20'd0, 6'($urandom_range(0, 63)), 2'b00}; l_wdata = $urandom;
      end
      #1;
      if ((c_req && !boot) && l_req) win = (!RR || !last_ldr) ? 2 : 1;
      else if (l_req)                win = 2;
      else if (c_req && !boot)       win = 1;
      else                           win = 0;
      waddr = (win == 2) ? l_addr : c_addr;
      wdata = (win == 2) ? l_wdata : c_wdata;
      wwe   = (win == 2) ? l_we : c_we;
      filt  = (win == 2) && (l_addr < 32'h8);
      n_tests++; if (c_gnt !== (win == 1) || l_gnt !== (win == 2))
        begin n_fail++; $display("FAIL rnd_gnt[%0d] got c=%b l=%b want winner %0d", cyc, c_gnt, l_gnt, win); end
      n_tests++; if (m_we !== (win != 0 && !filt && wwe) || m_re !== (win != 0 && !filt && !wwe))
        begin n_fail++; $display("FAIL rnd_m_ctrl[%0d] got we=%b re=%b", cyc, m_we, m_re); end
      n_tests++; if (m_addr !== ((win != 0) ? waddr : hold_addr))
        begin n_fail++; $display("FAIL rnd_m_addr[%0d] got %h want %h", cyc, m_addr, (win != 0) ? waddr : hold_addr); end
      if (win != 0 && !filt && wwe) begin
        n_tests++; if (m_wdata !== wdata) begin n_fail++; $display("FAIL rnd_m_wdata[%0d] got %h want %h", cyc, m_wdata, wdata); end
      end
      n_tests++; if (c_rvalid !== (pend_v && !pend_ldr) || l_rvalid !== (pend_v && pend_ldr))
        begin n_fail++; $display("FAIL rnd_rvalid[%0d] got c=%b l=%b want c=%b l=%b", cyc, c_rvalid, l_rvalid, pend_v && !pend_ldr, pend_v && pend_ldr); end
      if (pend_v) begin
        n_tests++; if ((pend_ldr ? l_rdata : c_rdata) !== pend_data)
          begin n_fail++; $display("FAIL rnd_rdata[%0d] got %h want %h", cyc, pend_ldr ? l_rdata : c_rdata, pend_data); end
      end
      n_tests++; if (busy_cnt !== 16'(exp_busy)) begin n_fail++; $display("FAIL rnd_busy[%0d] got %0d want %0d", cyc, busy_cnt, exp_busy); end
      pend_v = (win != 0) && !wwe;
      pend_ldr = (win == 2);
      pend_data = filt ? 32'h0 : ref_mem[waddr[11:2]];
      if (win != 0 && !filt && wwe) ref_mem[waddr[11:2]] = wdata;
      if ((c_req && win != 1) || (l_req && win != 2)) exp_busy++;
      c_hold = c_req && (win != 1);
      l_hold = l_req && (win != 2);
      if (win != 0) begin
        hold_addr = waddr;
        last_ldr = (win == 2);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0; m_rdata = '0;
    idle_inputs();
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
    preload();
    test_reset();
    test_cpu_read();
    test_conflict();
    test_mmio_filter();
    test_back_to_back();
    test_boot();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
